line_fetch_sched: RTL and testbench

LINE_FETCH_SCHED -- requirements
Module: line_fetch_sched

---
 rtl/line_fetch_sched_if.sv | 41 ++++
 rtl/line_fetch_sched.sv | 172 +++++++++++++++++
 tb/tb_line_fetch_sched.sv | 389 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/line_fetch_sched_if.sv
// Bundle of every line_fetch_sched signal except clock and reset.
// Ports: video timing {HS,VS,DE}; host request/ack/read return; shared RAM port;
//        fetched-slot stream; line index and sticky overrun flag.
// slave = scheduler view, master = environment (timing gen, host, RAM, renderer) view.
interface line_fetch_sched_if #(
  parameter int AW = 12,
  parameter int DW = 16
);
  logic [2:0]    VID_HVD_i;
  logic          HOST_REQ_i;
  logic          HOST_WE_i;
  logic [AW-1:0] HOST_ADDR_i;
  logic [DW-1:0] HOST_WDATA_i;
  logic          HOST_ACK_o;
  logic          HOST_RVLD_o;
  logic [DW-1:0] HOST_RDATA_o;
  logic          RAM_CE_o;
  logic          RAM_WE_o;
  logic [AW-1:0] RAM_ADDR_o;
  logic [DW-1:0] RAM_WDATA_o;
  logic [DW-1:0] RAM_RDATA_i;
  logic          FETCH_VLD_o;
  logic [DW-1:0] FETCH_DATA_o;
  logic [5:0]    FETCH_IDX_o;
  logic [9:0]    LINE_o;
  logic          OVR_o;

  modport slave (
    input  VID_HVD_i, HOST_REQ_i, HOST_WE_i, HOST_ADDR_i, HOST_WDATA_i, RAM_RDATA_i,
    output HOST_ACK_o, HOST_RVLD_o, HOST_RDATA_o,
    output RAM_CE_o, RAM_WE_o, RAM_ADDR_o, RAM_WDATA_o,
    output FETCH_VLD_o, FETCH_DATA_o, FETCH_IDX_o, LINE_o, OVR_o
  );

  modport master (
    output VID_HVD_i, HOST_REQ_i, HOST_WE_i, HOST_ADDR_i, HOST_WDATA_i, RAM_RDATA_i,
    input  HOST_ACK_o, HOST_RVLD_o, HOST_RDATA_o,
    input  RAM_CE_o, RAM_WE_o, RAM_ADDR_o, RAM_WDATA_o,
    input  FETCH_VLD_o, FETCH_DATA_o, FETCH_IDX_o, LINE_o, OVR_o
  );
endinterface

// File: rtl/line_fetch_sched.sv
// Shares one RAM port between per-line NSLOT-read bursts (VS rise / DE fall) and host accesses.
// Latency: RAM_* registered 1 cycle after trigger/request decision; read returns 2 cycles after RAM_CE_o.
// Backpressure: none downstream; host holds HOST_REQ_i while a burst owns the port, overlapping triggers set OVR_o.
// Ports: CLK_i, RST_i (sync, active-high) plain; bus (slave modport) carries all other signals.
module line_fetch_sched #(
  parameter int NSLOT = 16,
  parameter int AW    = 12,
  parameter int DW    = 16
) (
  input  logic              CLK_i,
  input  logic              RST_i,
  line_fetch_sched_if.slave bus
);
  localparam logic [5:0] LAST_SLOT = 6'(NSLOT - 1);

  typedef enum logic {S_IDLE = 1'b0, S_FETCH = 1'b1} state_t;

  state_t        r_state, w_state_nxt;
  logic          r_prev_vs, r_prev_de;
  logic          w_vs, w_de, w_vs_rise, w_de_fall, w_trig;
  logic          w_unused_hs;
  logic [AW-1:0] r_addr, w_addr_nxt;
  logic [5:0]    r_slot, w_slot_nxt;
  logic [9:0]    r_line, w_line_nxt;
  logic          r_ovr, w_ovr_nxt;

  // Access chosen this cycle; registered onto the RAM port at the next edge.
  logic          w_iss_ce, w_iss_we, w_iss_fetch, w_iss_host;
  logic [AW-1:0] w_iss_addr;
  logic [DW-1:0] w_iss_wdata;

  // Tag stage 0 travels with the registered RAM command; stage 1 lines up
  // with RAM_RDATA_i one cycle later.
  logic          r_t0_fetch, r_t0_hrd, r_t1_fetch, r_t1_hrd;
  logic [5:0]    r_t0_slot, r_t1_slot;

  logic          r_ram_ce, r_ram_we;
  logic [AW-1:0] r_ram_addr;
  logic [DW-1:0] r_ram_wdata;
  logic          r_host_ack, r_host_rvld;
  logic [DW-1:0] r_host_rdata;
  logic          r_fetch_vld;
  logic [DW-1:0] r_fetch_data;
  logic [5:0]    r_fetch_idx;

  assign w_unused_hs = bus.VID_HVD_i[2];
  assign w_vs        = bus.VID_HVD_i[1];
  assign w_de        = bus.VID_HVD_i[0];
  assign w_vs_rise   = w_vs & ~r_prev_vs;
  assign w_de_fall   = r_prev_de & ~w_de;
  assign w_trig      = w_vs_rise | w_de_fall;

  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    w_slot_nxt  = r_slot;
    w_line_nxt  = r_line;
    w_ovr_nxt   = r_ovr;
    w_iss_ce    = 1'b0;
    w_iss_we    = 1'b0;
    w_iss_fetch = 1'b0;
    w_iss_host  = 1'b0;
    w_iss_addr  = '0;
    w_iss_wdata = '0;
    case (r_state)
      S_IDLE: begin
        if (w_trig) begin
          // Fetch wins over a pending host request; VS rise wins over DE fall.
          w_state_nxt = S_FETCH;
          w_slot_nxt  = 6'd0;
          if (w_vs_rise) begin
            w_addr_nxt = '0;
            w_line_nxt = 10'd0;
          end else begin
            w_line_nxt = r_line + 10'd1;
          end
        end else if (bus.HOST_REQ_i) begin
          w_iss_ce    = 1'b1;
          w_iss_host  = 1'b1;
          w_iss_we    = bus.HOST_WE_i;
          w_iss_addr  = bus.HOST_ADDR_i;
          w_iss_wdata = bus.HOST_WDATA_i;
        end
      end
      S_FETCH: begin
        w_iss_ce    = 1'b1;
        w_iss_fetch = 1'b1;
        w_iss_addr  = r_addr;
        w_addr_nxt  = r_addr + AW'(1);
        w_slot_nxt  = r_slot + 6'd1;
        if (r_slot == LAST_SLOT) begin
          w_state_nxt = S_IDLE;
        end
        // A trigger landing inside a burst is dropped entirely; only flagged.
        if (w_trig) begin
          w_ovr_nxt = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK_i) begin
    if (RST_i) begin
      r_state      <= S_IDLE;
      r_prev_vs    <= 1'b0;
      r_prev_de    <= 1'b0;
      r_addr       <= '0;
      r_slot       <= 6'd0;
      r_line       <= 10'd0;
      r_ovr        <= 1'b0;
      r_ram_ce     <= 1'b0;
      r_ram_we     <= 1'b0;
      r_ram_addr   <= '0;
      r_ram_wdata  <= '0;
      r_host_ack   <= 1'b0;
      r_t0_fetch   <= 1'b0;
      r_t0_hrd     <= 1'b0;
      r_t0_slot    <= 6'd0;
      r_t1_fetch   <= 1'b0;
      r_t1_hrd     <= 1'b0;
      r_t1_slot    <= 6'd0;
      r_fetch_vld  <= 1'b0;
      r_fetch_data <= '0;
      r_fetch_idx  <= 6'd0;
      r_host_rvld  <= 1'b0;
      r_host_rdata <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_prev_vs   <= w_vs;
      r_prev_de   <= w_de;
      r_addr      <= w_addr_nxt;
      r_slot      <= w_slot_nxt;
      r_line      <= w_line_nxt;
      r_ovr       <= w_ovr_nxt;
      r_ram_ce    <= w_iss_ce;
      r_ram_we    <= w_iss_we;
      r_ram_addr  <= w_iss_addr;
      r_ram_wdata <= w_iss_wdata;
      r_host_ack  <= w_iss_host;
      r_t0_fetch  <= w_iss_fetch;
      r_t0_hrd    <= w_iss_host & ~w_iss_we;
      r_t0_slot   <= w_iss_fetch ? r_slot : 6'd0;
      r_t1_fetch  <= r_t0_fetch;
      r_t1_hrd    <= r_t0_hrd;
      r_t1_slot   <= r_t0_slot;
      r_fetch_vld <= r_t1_fetch;
      r_host_rvld <= r_t1_hrd;
      // Data/index registers hold their last value between returns.
      if (r_t1_fetch) begin
        r_fetch_data <= bus.RAM_RDATA_i;
        r_fetch_idx  <= r_t1_slot;
      end
      if (r_t1_hrd) begin
        r_host_rdata <= bus.RAM_RDATA_i;
      end
    end
  end

  assign bus.RAM_CE_o     = r_ram_ce;
  assign bus.RAM_WE_o     = r_ram_we;
  assign bus.RAM_ADDR_o   = r_ram_addr;
  assign bus.RAM_WDATA_o  = r_ram_wdata;
  assign bus.HOST_ACK_o   = r_host_ack;
  assign bus.HOST_RVLD_o  = r_host_rvld;
  assign bus.HOST_RDATA_o = r_host_rdata;
  assign bus.FETCH_VLD_o  = r_fetch_vld;
  assign bus.FETCH_DATA_o = r_fetch_data;
  assign bus.FETCH_IDX_o  = r_fetch_idx;
  assign bus.LINE_o       = r_line;
  assign bus.OVR_o        = r_ovr;
endmodule

// File: tb/tb_line_fetch_sched.sv
// Bench for line_fetch_sched: RAM model, event monitor, per-scenario tasks with scoreboards.
// Expected events are pushed when stimulus is driven and compared against the monitor log.
// A second instance with AW=4 shares the video timing to show address wrap.
module tb_line_fetch_sched;
  typedef struct packed {
    logic [31:0] cyc;
    logic        we;
    logic [11:0] addr;
    logic [15:0] dat;
  } ev_t;

  localparam int K_CE = 0, K_ACK = 1, K_FV = 2, K_RV = 3, K_CE4 = 4;

  logic        clk = 1'b0;
  logic        rst;
  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;
  logic [15:0] mem [4096];
  ev_t         act_q [5][$];
  ev_t         exp_q [5][$];
  string       kname [5] = '{"ce", "ack", "fetch", "rvld", "ce_aw4"};

  line_fetch_sched_if #(.AW(12), .DW(16)) bus ();
  line_fetch_sched_if #(.AW(4),  .DW(16)) bus4 ();

  line_fetch_sched #(.NSLOT(16), .AW(12), .DW(16)) u_dut (
    .CLK_i(clk), .RST_i(rst), .bus(bus));
  line_fetch_sched #(.NSLOT(16), .AW(4), .DW(16)) u_dut4 (
    .CLK_i(clk), .RST_i(rst), .bus(bus4));

  assign bus4.VID_HVD_i    = bus.VID_HVD_i;
  assign bus4.HOST_REQ_i   = 1'b0;
  assign bus4.HOST_WE_i    = 1'b0;
  assign bus4.HOST_ADDR_i  = 4'd0;
  assign bus4.HOST_WDATA_i = 16'd0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM models: one-cycle read latency.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4096; i++) mem[i] <= 16'(i * 311 + 16'h2000);
    end else if (bus.RAM_CE_o) begin
      if (bus.RAM_WE_o) mem[bus.RAM_ADDR_o] <= bus.RAM_WDATA_o;
      else              bus.RAM_RDATA_i <= mem[bus.RAM_ADDR_o];
    end
  end
  always @(posedge clk) begin
    if (bus4.RAM_CE_o && !bus4.RAM_WE_o) bus4.RAM_RDATA_i <= 16'(bus4.RAM_ADDR_o) ^ 16'h5A00;
  end

  function automatic ev_t mk(input int c, input logic we, input logic [11:0] a, input logic [15:0] d);
    ev_t e;
    e.cyc = 32'(c); e.we = we; e.addr = a; e.dat = d;
    return e;
  endfunction

  function automatic string evs(input ev_t e);
    return $sformatf("cyc=%0d we=%b addr=%h dat=%h", e.cyc, e.we, e.addr, e.dat);
  endfunction

  // Monitor: log every output event with the cycle it was seen in.
  always @(negedge clk) begin
    if (bus.RAM_CE_o === 1'b1)
      act_q[K_CE].push_back(mk(cyc, bus.RAM_WE_o, bus.RAM_ADDR_o, bus.RAM_WDATA_o));
    if (bus.HOST_ACK_o === 1'b1)  act_q[K_ACK].push_back(mk(cyc, 1'b0, 12'd0, 16'd0));
    if (bus.FETCH_VLD_o === 1'b1)
      act_q[K_FV].push_back(mk(cyc, 1'b0, 12'(bus.FETCH_IDX_o), bus.FETCH_DATA_o));
    if (bus.HOST_RVLD_o === 1'b1) act_q[K_RV].push_back(mk(cyc, 1'b0, 12'd0, bus.HOST_RDATA_o));
    if (bus4.RAM_CE_o === 1'b1)
      act_q[K_CE4].push_back(mk(cyc, bus4.RAM_WE_o, 12'(bus4.RAM_ADDR_o), bus4.RAM_WDATA_o));
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    for (int k = 0; k < 5; k++) begin
      act_q[k].delete();
      exp_q[k].delete();
    end
  endtask

  task automatic push(input int k, input int c, input logic we, input logic [11:0] a, input logic [15:0] d);
    exp_q[k].push_back(mk(c, we, a, d));
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(3);
    @(negedge clk);
    checks++;
    if ({bus.RAM_CE_o, bus.RAM_WE_o, bus.RAM_ADDR_o, bus.RAM_WDATA_o} !== 30'd0) begin
      errors++; $display("FAIL reset_ram got ce=%b we=%b addr=%h wdata=%h want all 0",
                         bus.RAM_CE_o, bus.RAM_WE_o, bus.RAM_ADDR_o, bus.RAM_WDATA_o);
    end
    checks++;
    if ({bus.HOST_ACK_o, bus.HOST_RVLD_o, bus.HOST_RDATA_o} !== 18'd0) begin
      errors++; $display("FAIL reset_host got ack=%b rvld=%b rdata=%h want all 0",
                         bus.HOST_ACK_o, bus.HOST_RVLD_o, bus.HOST_RDATA_o);
    end
    checks++;
    if ({bus.FETCH_VLD_o, bus.FETCH_DATA_o, bus.FETCH_IDX_o} !== 23'd0) begin
      errors++; $display("FAIL reset_fetch got vld=%b data=%h idx=%0d want all 0",
                         bus.FETCH_VLD_o, bus.FETCH_DATA_o, bus.FETCH_IDX_o);
    end
    checks++;
    if ({bus.LINE_o, bus.OVR_o} !== 11'd0) begin
      errors++; $display("FAIL reset_line got line=%0d ovr=%b want 0 0", bus.LINE_o, bus.OVR_o);
    end
    tick(1);
    rst = 1'b0;
    clear_logs();
    tick(6);
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (act_q[k].size() != 0) begin
        errors++; $display("FAIL reset_idle %s count got %0d want 0", kname[k], act_q[k].size());
      end
    end
  endtask

  task automatic test_vs_burst();
    int d;
    tick(1); clear_logs(); d = cyc;
    bus.VID_HVD_i = 3'b010;
    for (int i = 0; i < 16; i++) begin
      push(K_CE, d + 2 + i, 1'b0, 12'(i), 16'd0);
      push(K_FV, d + 4 + i, 1'b0, 12'(i), mem[i]);
    end
    tick(1); bus.VID_HVD_i = 3'b000;
    tick(25);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (act_q[k].size() != exp_q[k].size()) begin
        errors++; $display("FAIL vs_burst %s count got %0d want %0d", kname[k], act_q[k].size(), exp_q[k].size());
      end
      for (int i = 0; i < exp_q[k].size() && i < act_q[k].size(); i++) begin
        checks++;
        if (act_q[k][i] !== exp_q[k][i]) begin
          errors++; $display("FAIL vs_burst %s[%0d] got %s want %s", kname[k], i, evs(act_q[k][i]), evs(exp_q[k][i]));
        end
      end
    end
    @(negedge clk);
    checks++;
    if (bus.LINE_o !== 10'd0) begin
      errors++; $display("FAIL vs_burst line got %0d want 0", bus.LINE_o);
    end
  endtask

  task automatic test_line_advance();
    int d;
    tick(1); clear_logs(); d = cyc;
    bus.VID_HVD_i = 3'b001;
    for (int i = 0; i < 16; i++) begin
      push(K_CE,  d + 3 + i, 1'b0, 12'(16 + i), 16'd0);
      push(K_FV,  d + 5 + i, 1'b0, 12'(i), mem[16 + i]);
      push(K_CE4, d + 3 + i, 1'b0, 12'(i), 16'd0);
    end
    tick(1); bus.VID_HVD_i = 3'b000;
    tick(25);
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (act_q[k].size() != exp_q[k].size()) begin
        errors++; $display("FAIL line_adv %s count got %0d want %0d", kname[k], act_q[k].size(), exp_q[k].size());
      end
      for (int i = 0; i < exp_q[k].size() && i < act_q[k].size(); i++) begin
        checks++;
        if (act_q[k][i] !== exp_q[k][i]) begin
          errors++; $display("FAIL line_adv %s[%0d] got %s want %s", kname[k], i, evs(act_q[k][i]), evs(exp_q[k][i]));
        end
      end
    end
    @(negedge clk);
    checks++;
    if (bus.LINE_o !== 10'd1) begin
      errors++; $display("FAIL line_adv line got %0d want 1", bus.LINE_o);
    end
    checks++;
    if (bus4.LINE_o !== 10'd1) begin
      errors++; $display("FAIL line_adv line_aw4 got %0d want 1", bus4.LINE_o);
    end
  endtask

  task automatic test_host_priority();
    int d;
    tick(1); clear_logs(); d = cyc;
    bus.VID_HVD_i = 3'b001;
    tick(1);
    bus.VID_HVD_i    = 3'b000;
    bus.HOST_REQ_i   = 1'b1;
    bus.HOST_WE_i    = 1'b0;
    bus.HOST_ADDR_i  = 12'd5;
    bus.HOST_WDATA_i = 16'd0;
    for (int i = 0; i < 16; i++) begin
      push(K_CE, d + 3 + i, 1'b0, 12'(32 + i), 16'd0);
      push(K_FV, d + 5 + i, 1'b0, 12'(i), mem[32 + i]);
    end
    push(K_CE,  d + 19, 1'b0, 12'd5, 16'd0);
    push(K_ACK, d + 19, 1'b0, 12'd0, 16'd0);
    push(K_RV,  d + 21, 1'b0, 12'd0, mem[5]);
    tick(18);
    bus.HOST_REQ_i = 1'b0;
    tick(8);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (act_q[k].size() != exp_q[k].size()) begin
        errors++; $display("FAIL host_prio %s count got %0d want %0d", kname[k], act_q[k].size(), exp_q[k].size());
      end
      for (int i = 0; i < exp_q[k].size() && i < act_q[k].size(); i++) begin
        checks++;
        if (act_q[k][i] !== exp_q[k][i]) begin
          errors++; $display("FAIL host_prio %s[%0d] got %s want %s", kname[k], i, evs(act_q[k][i]), evs(exp_q[k][i]));
        end
      end
    end
    @(negedge clk);
    checks++;
    if (bus.LINE_o !== 10'd2) begin
      errors++; $display("FAIL host_prio line got %0d want 2", bus.LINE_o);
    end
  endtask

  task automatic test_overrun();
    int d;
    tick(1); clear_logs(); d = cyc;
    bus.VID_HVD_i = 3'b001;
    for (int i = 0; i < 16; i++) begin
      push(K_CE, d + 3 + i, 1'b0, 12'(48 + i), 16'd0);
      push(K_FV, d + 5 + i, 1'b0, 12'(i), mem[48 + i]);
    end
    tick(1); bus.VID_HVD_i = 3'b000;
    tick(7);
    @(negedge clk);
    checks++;
    if (bus.OVR_o !== 1'b0) begin
      errors++; $display("FAIL overrun ovr_before got %b want 0", bus.OVR_o);
    end
    tick(1); bus.VID_HVD_i = 3'b001;
    tick(1); bus.VID_HVD_i = 3'b000;   // de_fall while slot 8 is being issued
    tick(30);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (act_q[k].size() != exp_q[k].size()) begin
        errors++; $display("FAIL overrun %s count got %0d want %0d", kname[k], act_q[k].size(), exp_q[k].size());
      end
      for (int i = 0; i < exp_q[k].size() && i < act_q[k].size(); i++) begin
        checks++;
        if (act_q[k][i] !== exp_q[k][i]) begin
          errors++; $display("FAIL overrun %s[%0d] got %s want %s", kname[k], i, evs(act_q[k][i]), evs(exp_q[k][i]));
        end
      end
    end
    @(negedge clk);
    checks++;
    if (bus.OVR_o !== 1'b1) begin
      errors++; $display("FAIL overrun ovr_after got %b want 1", bus.OVR_o);
    end
  endtask

  task automatic test_simultaneous();
    int d;
    tick(1); clear_logs(); d = cyc;
    bus.VID_HVD_i = 3'b001;
    tick(1); bus.VID_HVD_i = 3'b010;   // VS rises as DE falls
    for (int i = 0; i < 16; i++) begin
      push(K_CE, d + 3 + i, 1'b0, 12'(i), 16'd0);
      push(K_FV, d + 5 + i, 1'b0, 12'(i), mem[i]);
    end
    tick(1); bus.VID_HVD_i = 3'b000;
    tick(25);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (act_q[k].size() != exp_q[k].size()) begin
        errors++; $display("FAIL simul %s count got %0d want %0d", kname[k], act_q[k].size(), exp_q[k].size());
      end
      for (int i = 0; i < exp_q[k].size() && i < act_q[k].size(); i++) begin
        checks++;
        if (act_q[k][i] !== exp_q[k][i]) begin
          errors++; $display("FAIL simul %s[%0d] got %s want %s", kname[k], i, evs(act_q[k][i]), evs(exp_q[k][i]));
        end
      end
    end
    @(negedge clk);
    checks++;
    if (bus.LINE_o !== 10'd0) begin
      errors++; $display("FAIL simul line got %0d want 0", bus.LINE_o);
    end
    checks++;
    if (bus.OVR_o !== 1'b1) begin
      errors++; $display("FAIL simul ovr_sticky got %b want 1", bus.OVR_o);
    end
  endtask

  task automatic test_back_to_back();
    int d;
    tick(1); clear_logs(); d = cyc;
    bus.HOST_REQ_i   = 1'b1;
    bus.HOST_WE_i    = 1'b1;
    bus.HOST_ADDR_i  = 12'd9;
    bus.HOST_WDATA_i = 16'hBEEF;
    push(K_CE,  d + 1, 1'b1, 12'd9, 16'hBEEF);
    push(K_ACK, d + 1, 1'b0, 12'd0, 16'd0);
    tick(1);
    bus.HOST_WE_i    = 1'b0;
    bus.HOST_WDATA_i = 16'd0;
    push(K_CE,  d + 2, 1'b0, 12'd9, 16'd0);
    push(K_ACK, d + 2, 1'b0, 12'd0, 16'd0);
    push(K_RV,  d + 4, 1'b0, 12'd0, 16'hBEEF);
    tick(1);
    bus.HOST_REQ_i = 1'b0;
    tick(8);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (act_q[k].size() != exp_q[k].size()) begin
        errors++; $display("FAIL b2b %s count got %0d want %0d", kname[k], act_q[k].size(), exp_q[k].size());
      end
      for (int i = 0; i < exp_q[k].size() && i < act_q[k].size(); i++) begin
        checks++;
        if (act_q[k][i] !== exp_q[k][i]) begin
          errors++; $display("FAIL b2b %s[%0d] got %s want %s", kname[k], i, evs(act_q[k][i]), evs(exp_q[k][i]));
        end
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    int d;
    tick(1); clear_logs(); d = cyc;
    bus.VID_HVD_i = 3'b010;
    for (int i = 0; i < 8; i++) push(K_CE, d + 2 + i, 1'b0, 12'(i), 16'd0);
    for (int i = 0; i < 6; i++) push(K_FV, d + 4 + i, 1'b0, 12'(i), mem[i]);
    tick(1); bus.VID_HVD_i = 3'b000;
    tick(8);
    rst = 1'b1;                        // RAM port currently shows slot 7
    tick(1);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.RAM_CE_o !== 1'b0) begin
      errors++; $display("FAIL rst_mid ce got %b want 0", bus.RAM_CE_o);
    end
    checks++;
    if (bus.OVR_o !== 1'b0) begin
      errors++; $display("FAIL rst_mid ovr got %b want 0", bus.OVR_o);
    end
    checks++;
    if (bus.LINE_o !== 10'd0) begin
      errors++; $display("FAIL rst_mid line got %0d want 0", bus.LINE_o);
    end
    tick(20);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (act_q[k].size() != exp_q[k].size()) begin
        errors++; $display("FAIL rst_mid %s count got %0d want %0d", kname[k], act_q[k].size(), exp_q[k].size());
      end
      for (int i = 0; i < exp_q[k].size() && i < act_q[k].size(); i++) begin
        checks++;
        if (act_q[k][i] !== exp_q[k][i]) begin
          errors++; $display("FAIL rst_mid %s[%0d] got %s want %s", kname[k], i, evs(act_q[k][i]), evs(exp_q[k][i]));
        end
      end
    end
  endtask

  initial begin
    rst              = 1'b1;
    bus.VID_HVD_i    = 3'b000;
    bus.HOST_REQ_i   = 1'b0;
    bus.HOST_WE_i    = 1'b0;
    bus.HOST_ADDR_i  = 12'd0;
    bus.HOST_WDATA_i = 16'd0;
    test_reset();
    test_vs_burst();
    test_line_advance();
    test_host_priority();
    test_overrun();
    test_simultaneous();
    test_back_to_back();
    test_reset_mid_burst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
